oam_dma: RTL and testbench

//  Game Boy OAM DMA engine; the writer side of the 160-byte OAM memory.
//  - CPU write of page XX to register FF46 starts a copy of XX00..XX9F into OAM 0x00..0x9F.
//  - Sources are read over the system bus; sinks drive the OAM en/we/addr/din port.
//  - busy lets the bus arbiter block CPU access to OAM during a copy.

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma_if.sv | 24 ++
 rtl/dma_phase_ctr.sv | 38 +++
 rtl/oam_dma.sv | 92 +++++++++
 tb/tb_oam_dma.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
package oam_dma_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  ECHO_PAGE_LO = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

  // Echo RAM pages (E0..FF) are served from the C000-DFFF mirror.
  function automatic logic [7:0] src_page(input logic [7:0] page);
    return (page >= ECHO_PAGE_LO) ? page - ECHO_OFFSET : page;
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU register, source bus and OAM write port of the OAM DMA engine.
interface oam_dma_if;
  logic        reg_we;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        src_rd_en;
  logic [15:0] src_addr;
  logic [7:0]  src_din;
  logic        oam_en;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_dout;
  logic        busy;

  modport master (
    input  reg_we, reg_din, src_din,
    output reg_dout, src_rd_en, src_addr, oam_en, oam_we, oam_addr, oam_dout, busy
  );

  modport slave (
    output reg_we, reg_din, src_din,
    input  reg_dout, src_rd_en, src_addr, oam_en, oam_we, oam_addr, oam_dout, busy
  );
endinterface

// File: rtl/dma_phase_ctr.sv
// Modulo-CYCLES_PER_BYTE phase counter with synchronous clear.
module dma_phase_ctr #(
  parameter int unsigned CYCLES_PER_BYTE = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               en,
  output logic [$clog2(CYCLES_PER_BYTE)-1:0] phase,
  output logic                               last_phase
);

  localparam int unsigned PhaseW = $clog2(CYCLES_PER_BYTE);
  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(CYCLES_PER_BYTE - 1);

  logic [PhaseW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == LastPhase) ? '0 : phase_q + PhaseW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase      = phase_q;
  assign last_phase = (phase_q == LastPhase);

endmodule

// File: rtl/oam_dma.sv
// Game Boy OAM DMA engine: copies page XX00..XX9F into OAM after a write to FF46.
// Define OAM_DMA_STARTUP_DELAY_EN to insert one M-cycle START delay before the first read.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned OAM_BYTES       = 160
) (
  input  logic          clk,
  input  logic          reset,
  oam_dma_if.master     bus
);

  localparam int unsigned PhaseW = $clog2(CYCLES_PER_BYTE);

  dma_state_t        state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        index_q, index_d;
  logic [PhaseW-1:0] phase;
  logic              last_phase;
  logic              rd_phase, wr_phase;

  dma_phase_ctr #(
    .CYCLES_PER_BYTE(CYCLES_PER_BYTE)
  ) u_phase_ctr (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.reg_we),
    .en        (state_q != IDLE),
    .phase     (phase),
    .last_phase(last_phase)
  );

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    if (bus.reg_we) begin
      page_d  = bus.reg_din;
      index_d = '0;
`ifdef OAM_DMA_STARTUP_DELAY_EN
      state_d = START;
`else
      state_d = XFER;
`endif
    end else begin
      unique case (state_q)
        IDLE: ;
        START: if (last_phase) state_d = XFER;
        XFER: begin
          if (last_phase) begin
            if (index_q == 8'(OAM_BYTES - 1)) begin
              state_d = IDLE;
              index_d = '0;
            end else begin
              index_d = index_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'hFF;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
    end
  end

  // Read on phase 0; the bus returns data one clk later, written to OAM on phase 1.
  assign rd_phase = (state_q == XFER) && (phase == '0);
  assign wr_phase = (state_q == XFER) && (phase == PhaseW'(1));

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.reg_dout  = page_q;
    bus.src_rd_en = rd_phase;
    bus.src_addr  = rd_phase ? {src_page(page_q), index_q} : 16'h0000;
    bus.oam_en    = wr_phase;
    bus.oam_we    = wr_phase;
    bus.oam_addr  = wr_phase ? index_q : 8'h00;
    bus.oam_dout  = wr_phase ? bus.src_din : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: directed scenarios with random pages/data vs. a transfer model.
module tb_oam_dma;

  localparam int unsigned CPB  = 4;
  localparam int unsigned CPB2 = 2;
  localparam int unsigned NB   = 160;
`ifdef OAM_DMA_STARTUP_DELAY_EN
  localparam int unsigned D  = CPB;
  localparam int unsigned D2 = CPB2;
`else
  localparam int unsigned D  = 0;
  localparam int unsigned D2 = 0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  logic [7:0]  salt = 8'h9B;  // with page C1 this gives data = index ^ 8'h5A
  int          total = 0;
  int          bad = 0;

  ev_t rq[$], wq[$], wq2[$], erq[$], ewq[$];
  int unsigned busy_cnt, busy_first, busy_last, busy2_cnt, busy2_first;
  bit          busy_seen, busy2_seen;

  always #5 clk = ~clk;

  oam_dma_if bus ();
  oam_dma_if bus2 ();

  oam_dma #(.CYCLES_PER_BYTE(CPB), .OAM_BYTES(NB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  oam_dma #(.CYCLES_PER_BYTE(CPB2), .OAM_BYTES(NB)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ salt;
  endfunction

  function automatic logic [7:0] echo_map(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus model: data valid one clk after the request, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.src_din  <= bus.src_rd_en  ? mem_byte(bus.src_addr)  : 8'($urandom);
    bus2.src_din <= bus2.src_rd_en ? mem_byte(bus2.src_addr) : 8'($urandom);
  end

  always @(negedge clk) begin
    chk("we_eq_en", {31'd0, bus.oam_we}, {31'd0, bus.oam_en});
    if (bus.src_rd_en === 1'b1) rq.push_back('{cyc, bus.src_addr, 8'h00});
    if (bus.oam_en === 1'b1) wq.push_back('{cyc, {8'h00, bus.oam_addr}, bus.oam_dout});
    if (bus.busy === 1'b1) begin
      if (!busy_seen) busy_first = cyc;
      busy_seen = 1'b1;
      busy_last = cyc;
      busy_cnt++;
    end
    if (bus2.oam_en === 1'b1) wq2.push_back('{cyc, {8'h00, bus2.oam_addr}, bus2.oam_dout});
    if (bus2.busy === 1'b1) begin
      if (!busy2_seen) busy2_first = cyc;
      busy2_seen = 1'b1;
      busy2_cnt++;
    end
  end

  task automatic clear_logs();
    rq.delete(); wq.delete(); wq2.delete(); erq.delete(); ewq.delete();
    busy_cnt = 0; busy_seen = 1'b0; busy2_cnt = 0; busy2_seen = 1'b0;
  endtask

  // Expected events for n bytes of a transfer of page p accepted at cycle st.
  task automatic add_seg(input int unsigned st, input logic [7:0] p, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] a;
      a = {echo_map(p), 8'(i)};
      erq.push_back('{st + D + i * CPB, a, 8'h00});
      ewq.push_back('{st + D + i * CPB + 1, 16'(i), mem_byte(a)});
    end
  endtask

  // Pulse reg_we so the DUT samples it at the edge that starts cycle n.
  task automatic write_at(input bit sel, input logic [7:0] p, input int unsigned n,
                          output int unsigned st);
    while (cyc < n - 1) @(negedge clk);
    if (sel) begin bus2.reg_din = p; bus2.reg_we = 1'b1; end
    else begin bus.reg_din = p; bus.reg_we = 1'b1; end
    st = cyc + 1;
    @(negedge clk);
    bus.reg_we = 1'b0;
    bus2.reg_we = 1'b0;
  endtask

  task automatic write_now(input bit sel, input logic [7:0] p, output int unsigned st);
    @(negedge clk);
    write_at(sel, p, cyc + 1, st);
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    int n = 0;
    while ((sel ? bus2.busy : bus.busy) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, sel ? bus2.busy : bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_nrd"}, rq.size(), erq.size());
    chk({tag, "_nwr"}, wq.size(), ewq.size());
    for (int i = 0; i < rq.size() && i < erq.size(); i++) begin
      chk($sformatf("%s_r%0d_cyc", tag, i), rq[i].cyc, erq[i].cyc);
      chk($sformatf("%s_r%0d_addr", tag, i), {16'd0, rq[i].addr}, {16'd0, erq[i].addr});
    end
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) begin
      chk($sformatf("%s_w%0d_cyc", tag, i), wq[i].cyc, ewq[i].cyc);
      chk($sformatf("%s_w%0d_addr", tag, i), {16'd0, wq[i].addr}, {16'd0, ewq[i].addr});
      chk($sformatf("%s_w%0d_data", tag, i), {24'd0, wq[i].data}, {24'd0, ewq[i].data});
    end
  endtask

  task automatic check_busy(input string tag, input int unsigned st, input int unsigned len);
    chk({tag, "_busy_first"}, busy_first, st);
    chk({tag, "_busy_len"}, busy_cnt, len);
    chk({tag, "_busy_cont"}, busy_last - busy_first + 1, len);
  endtask

  initial begin
    int unsigned st, st2, r;
    logic [7:0]  p;
    bus.reg_we = 1'b0; bus.reg_din = 8'h00;
    bus2.reg_we = 1'b0; bus2.reg_din = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_reg_dout", {24'd0, bus.reg_dout}, 32'hFF);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.src_rd_en}, 32'd0);
    chk("rst_oam_en", {31'd0, bus.oam_en}, 32'd0);
    chk("rst_oam_we", {31'd0, bus.oam_we}, 32'd0);
    chk("rst_src_addr", {16'd0, bus.src_addr}, 32'd0);
    chk("rst_oam_addr", {24'd0, bus.oam_addr}, 32'd0);
    chk("rst_oam_dout", {24'd0, bus.oam_dout}, 32'd0);
    chk("rst_busy2", {31'd0, bus2.busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain transfer from C1 (data = index ^ 5A).
    clear_logs();
    write_now(1'b0, 8'hC1, st);
    add_seg(st, 8'hC1, NB);
    wait_idle(1'b0, "c1");
    check_logs("c1");
    check_busy("c1", st, D + NB * CPB);

    // Echo page E3 plus random pages and data.
    for (int k = 0; k < 4; k++) begin
      p = (k == 0) ? 8'hE3 : 8'($urandom_range(0, 255));
      salt = 8'($urandom);
      clear_logs();
      write_now(1'b0, p, st);
      add_seg(st, p, NB);
      wait_idle(1'b0, $sformatf("pg%0d", k));
      check_logs($sformatf("pg%0d", k));
      check_busy($sformatf("pg%0d", k), st, D + NB * CPB);
      chk($sformatf("pg%0d_readback", k), {24'd0, bus.reg_dout}, {24'd0, p});
    end

    // Rewrite D0 just as byte 80 of a C0 transfer would begin.
    salt = 8'($urandom);
    clear_logs();
    write_now(1'b0, 8'hC0, st);
    write_at(1'b0, 8'hD0, st + D + 80 * CPB, st2);
    add_seg(st, 8'hC0, 80);
    add_seg(st2, 8'hD0, NB);
    wait_idle(1'b0, "restart");
    check_logs("restart");
    check_busy("restart", st, (st2 - st) + D + NB * CPB);

    // Reset during byte 50 phase 2 aborts after 51 writes.
    salt = 8'($urandom);
    clear_logs();
    write_now(1'b0, 8'h12, st);
    r = st + D + 50 * CPB + 2;
    while (cyc < r) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_rd_en", {31'd0, bus.src_rd_en}, 32'd0);
    chk("abort_oam_en", {31'd0, bus.oam_en}, 32'd0);
    chk("abort_reg_dout", {24'd0, bus.reg_dout}, 32'hFF);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    add_seg(st, 8'h12, 51);
    check_logs("abort");
    check_busy("abort", st, r - st + 1);

    // reg_we during the phase-1 write of byte 159: that write lands, then a new copy.
    salt = 8'($urandom);
    clear_logs();
    write_now(1'b0, 8'h80, st);
    write_at(1'b0, 8'h81, st + D + 159 * CPB + 2, st2);
    add_seg(st, 8'h80, NB);
    add_seg(st2, 8'h81, NB);
    wait_idle(1'b0, "edge159");
    check_logs("edge159");
    check_busy("edge159", st, (st2 - st) + D + NB * CPB);

    // Two clocks per byte.
    salt = 8'($urandom);
    clear_logs();
    write_now(1'b1, 8'h45, st);
    wait_idle(1'b1, "cpb2");
    chk("cpb2_nwr", wq2.size(), NB);
    for (int i = 0; i < wq2.size(); i++) begin
      chk($sformatf("cpb2_w%0d_cyc", i), wq2[i].cyc, st + D2 + i * CPB2 + 1);
      chk($sformatf("cpb2_w%0d_addr", i), {16'd0, wq2[i].addr}, i);
      chk($sformatf("cpb2_w%0d_data", i), {24'd0, wq2[i].data},
          {24'd0, mem_byte({8'h45, 8'(i)})});
    end
    chk("cpb2_busy_first", busy2_first, st);
    chk("cpb2_busy_len", busy2_cnt, D2 + NB * CPB2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
